// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: state encoding, segment
// table and the "everything off" patterns for the active-low display pins.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [7:0] an_onehot_low(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit time-multiplexed common-anode driver with blanking between
// digits, per-frame input snapshot and optional leading-zero suppression.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_en,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_idx;

    logic [31:0]       r_data_sh;
    logic [7:0]        r_dp_sh;
    logic [7:0]        r_en_sh;
    logic              r_lz_sh;

    logic [7:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    // The snapshot is taken on the same edge that lights digit 0, so that
    // digit's outputs must come from the live inputs rather than the old shadow.
    logic              w_blank_done;
    logic              w_show_done;
    logic              w_capture;
    logic [31:0]       w_data;
    logic [7:0]        w_dp_en;
    logic [7:0]        w_digit_en;
    logic              w_lz;

    assign w_blank_done = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
    assign w_show_done  = (r_state == ST_SHOW)  && (r_cnt == SHOW_LAST);
    assign w_capture    = w_blank_done && (r_idx == 3'd0);

    assign w_data     = w_capture ? data     : r_data_sh;
    assign w_dp_en    = w_capture ? dp_en    : r_dp_sh;
    assign w_digit_en = w_capture ? digit_en : r_en_sh;
    assign w_lz       = w_capture ? blank_lz : r_lz_sh;

    // w_upper_zero[i] is set when nibbles i..7 are all zero.
    logic [7:0] w_upper_zero;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lz
            assign w_upper_zero[gi] = (w_data[31:4*gi] == '0);
        end
    endgenerate

    logic [3:0] w_nib;
    logic [6:0] w_dec_seg;
    logic       w_en;
    logic       w_suppress;
    logic [7:0] w_an_lit;
    logic [6:0] w_seg_lit;
    logic       w_dp_lit;

    assign w_nib = w_data[{r_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_dec_seg)
    );

    assign w_en       = w_digit_en[r_idx];
    assign w_suppress = w_lz && (r_idx != 3'd0) && w_upper_zero[r_idx];

    // A suppressed digit keeps its anode and decimal point; only segments go dark.
    assign w_an_lit  = w_en ? an_onehot_low(r_idx) : AN_OFF;
    assign w_seg_lit = (w_en && !w_suppress) ? w_dec_seg : SEG_OFF;
    assign w_dp_lit  = w_en ? ~w_dp_en[r_idx] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_BLANK;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_data_sh <= '0;
            r_dp_sh   <= '0;
            r_en_sh   <= '0;
            r_lz_sh   <= 1'b0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_OFF;
            r_dp      <= 1'b1;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (w_blank_done) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                        r_an    <= w_an_lit;
                        r_seg   <= w_seg_lit;
                        r_dp    <= w_dp_lit;
                        if (w_capture) begin
                            r_data_sh <= data;
                            r_dp_sh   <= dp_en;
                            r_en_sh   <= digit_en;
                            r_lz_sh   <= blank_lz;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (w_show_done) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 3'd1;
                        r_an    <= AN_OFF;
                        r_seg   <= SEG_OFF;
                        r_dp    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                    r_an    <= AN_OFF;
                    r_seg   <= SEG_OFF;
                    r_dp    <= 1'b1;
                end
            endcase
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed driver for an 8-digit common-anode seven-segment display.
- Sits directly downstream of the matrix-keypad decoder. The system packs the keypad's 4-bit key value, plus any other status nibbles, into a 32-bit word.
- This block scans the word out one hex digit at a time. It provides anti-ghosting blanking, per-digit enables, decimal points and optional leading-zero suppression.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is lit (SHOW slot length); must be at least 1.
- BLANK_CYC, 500: clk cycles all anodes are off between digits (BLANK slot length); must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- data  in  32  hex digits; data[4i+3:4i] is digit i, digit 0 rightmost
- dp_en  in  8  bit i lights the decimal point of digit i
- digit_en  in  8  bit i enables digit i; 0 keeps the anode off for that slot
- blank_lz  in  1  1 suppresses leading zeros
- an  out  8  anodes, active-low, one-hot-low when lit
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low

Behaviour:
- Reset values: an=8'hFF, seg=7'h7F, dp=1. state=BLANK, idx=0, cnt=0, shadow registers 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states:
  - BLANK: an all 1, seg 7'h7F, dp 1. Stays for BLANK_CYC cycles, then goes to SHOW.
  - SHOW: drives digit idx for REFRESH_DIV cycles, then goes to BLANK with idx=idx+1 mod 8 (7 wraps to 0).
- Slot counter cnt resets to 0 on every state change.
- Frame length is 8*(BLANK_CYC+REFRESH_DIV) cycles.
- Timing: count the first rising edge after rst deasserts as edge 1. Then an[0] goes low on edge BLANK_CYC and stays low for exactly REFRESH_DIV cycles.
- Shadow capture:
  - data, dp_en, digit_en and blank_lz are captured into shadow registers on the BLANK->SHOW edge for idx=0 only.
  - The whole frame displays a consistent snapshot; there is no tearing.
  - Inputs changing mid-frame take effect at the next digit-0 slot.
- Leading-zero suppression uses shadow values. When blank_lz=1, digit i is suppressed iff:
  - i>0, and
  - shadow nibbles i..7 are all zero.
- Digit 0 is never suppressed.
- SHOW outputs for digit idx:
  - an[idx]=0 iff digit_en[idx]; all other an bits are 1.
  - seg = hex decode of the nibble, or 7'h7F if suppressed or not enabled.
  - dp = ~dp_en[idx] if enabled; a suppressed digit still shows its dp.
- Hex decode (active-low, hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- A disabled digit still consumes its full slot; the scan timing never changes.
- rst asserted mid-operation: outputs go to reset values immediately and asynchronously; the scan restarts at the BLANK slot of digit 0.
- Minimum parameter values: with REFRESH_DIV=1 and BLANK_CYC=1, the block alternates each cycle between blank and a single lit digit.

Decomposition:
- seg7_pkg holds:
  - the state encoding constants (BLANK, SHOW);
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF=7'h7F and AN_OFF=8'hFF.
- One combinational sub-module, seg7_decode: 4-bit nibble in, 7-bit active-low segments out.
- Counter width is $clog2 of max(REFRESH_DIV, BLANK_CYC)+1.

Test Plan:
1. Reset values and first slot.
   - Setup: REFRESH_DIV=4, BLANK_CYC=2, data=32'h76543210, digit_en=FF, blank_lz=0, dp_en=00.
   - Required: an=FF, seg=7F during reset.
   - Required: an=FE with seg=40 from edge 2 for 4 cycles, then FF for 2 cycles, then an=FD with seg=79; frame period 48 cycles.
2. Shadow capture.
   - Stimulus: change data to 32'h89ABCDEF while digit 3 is lit.
   - Required: digits 4..7 of the current frame still show 4,5,6,7.
   - Required: from the next digit-0 slot, seg=0E (F), then 06 (E).
3. Leading-zero suppression.
   - Stimulus: data=32'h00000A05, blank_lz=1.
   - Required: digits 0..2 show 12, 40, 08.
   - Required: digits 3..7 show seg=7F with their anode still asserted.
   - Required: with data=0, digit 0 shows 40 and digits 1..7 are blank.
4. Digit enable and decimal points.
   - Stimulus: digit_en=8'h0F, dp_en=8'h02.
   - Required: an stays FF during the slots for digits 4..7.
   - Required: dp=0 only while an=FD.
5. Reset mid-frame.
   - Stimulus: assert rst during digit 5's SHOW slot.
   - Required: an=FF and seg=7F immediately, without waiting for a clock edge.
   - Required: after release, the first lit anode is FE on edge BLANK_CYC.
6. Exhaustive decode.
   - Stimulus: sweep each nibble 0..F on digit 0.
   - Required: seg matches the hex table for all 16 values.
